// File: rtl/am_pkg.sv
// Shared types and constants for the multi-channel AM tone generator,
// including the elaboration-time sine table generator used by sine_LUT.
package am_pkg;

   typedef enum logic [1:0] {
      AM_MODE       = 2'd0,
      CW_MODE       = 2'd1,
      MUTE_MODE     = 2'd2,
      MUTE_ALT_MODE = 2'd3
   } am_mode_e;

   localparam logic [31:0] FREQ_STEP_500K = 32'h028F5C29;

   // pi scaled by 2**30
   localparam longint PI_Q30 = 64'sd3373259426;

   // Offset-binary sine code for table entry addr of a 2**addr_bits table:
   // 2**(sine_bits-1) + round((2**(sine_bits-1)-1) * sin(2*pi*addr/2**addr_bits)).
   // Quarter-wave folding plus a Q30 Taylor series keeps this integer-only.
   function automatic int sine_code(input int addr, input int addr_bits, input int sine_bits);
      longint   quarter;
      longint   r;
      longint   m;
      longint   x;
      longint   x2;
      longint   term;
      longint   acc;
      longint   half_amp;
      logic [1:0] quad;
      quarter = longint'(1) << (addr_bits - 2);
      quad    = 2'((addr >> (addr_bits - 2)) & 3);
      r       = longint'(addr) & (quarter - 1);
      m       = quad[0] ? (quarter - r) : r;
      x       = (m * PI_Q30 * 2) >>> addr_bits;
      x2      = (x * x) >>> 30;
      term    = x;
      acc     = x;
      for (int k = 1; k <= 7; k++) begin
         term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
         acc  = acc + term;
      end
      if (quad[1]) begin
         acc = -acc;
      end
      half_amp = (longint'(1) << (sine_bits - 1)) - 1;
      acc      = (half_amp * acc + (longint'(1) << 29)) >>> 30;
      return int'((longint'(1) << (sine_bits - 1)) + acc);
   endfunction

endpackage

// File: rtl/am_mod_multi_if.sv
// Configuration and sample-output bus of am_mod_multi; the generator is the
// slave, whoever programs channels and consumes samples is the master.
interface am_mod_multi_if #(
   parameter int NUM_CH      = 4,
   parameter int WIDTH       = 13,
   parameter int SINE_WIDTH  = 7,
   parameter int PHASE_WIDTH = 32
);
   localparam int CH_W = $clog2(NUM_CH);

   logic                   cfg_we;
   logic [CH_W-1:0]        cfg_ch;
   logic [PHASE_WIDTH-1:0] cfg_step;
   logic [WIDTH-1:0]       cfg_amp;
   logic [1:0]             cfg_mode;
   logic                   cfg_phase_clr;

   logic                   out_valid;
   logic [CH_W-1:0]        out_ch;
   logic [SINE_WIDTH-1:0]  out_sample;

   modport master (
      output cfg_we, cfg_ch, cfg_step, cfg_amp, cfg_mode, cfg_phase_clr,
      input  out_valid, out_ch, out_sample
   );

   modport slave (
      input  cfg_we, cfg_ch, cfg_step, cfg_amp, cfg_mode, cfg_phase_clr,
      output out_valid, out_ch, out_sample
   );

endinterface

// File: rtl/sine_LUT.sv
// Full-wave offset-binary sine ROM with a registered read, shared by all
// channels; contents are fixed at elaboration.
module sine_LUT
   import am_pkg::*;
#(
   parameter int PHASE_INTEGER_WIDTH = 12,
   parameter int SINE_WIDTH          = 7
) (
   input  logic                           clk,
   input  logic                           enable,
   input  logic [PHASE_INTEGER_WIDTH-1:0] phase,
   output logic [SINE_WIDTH-1:0]          sine
);
   localparam int DEPTH = 2 ** PHASE_INTEGER_WIDTH;

   logic [SINE_WIDTH-1:0] rom [DEPTH];
   logic [SINE_WIDTH-1:0] sine_q;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
         localparam int CODE = sine_code(gi, PHASE_INTEGER_WIDTH, SINE_WIDTH);
         assign rom[gi] = SINE_WIDTH'(CODE);
      end
   endgenerate

   // No reset on the read register so the ROM maps onto block RAM.
   always_ff @(posedge clk) begin
      if (enable) begin
         sine_q <= rom[phase];
      end
   end

   assign sine = sine_q;

endmodule

// File: rtl/am_mod_multi.sv
// Time-multiplexed AM tone generator: NUM_CH channels share one sine ROM and
// one multiplier through an issue -> LUT -> multiply -> output pipeline.
module am_mod_multi
   import am_pkg::*;
#(
   parameter int NUM_CH              = 4,
   parameter int WIDTH               = 13,
   parameter int SINE_WIDTH          = 7,
   parameter int PHASE_WIDTH         = 32,
   parameter int PHASE_INTEGER_WIDTH = 12,
   parameter int LOG2_MAX_DIST       = 11
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enable,
   am_mod_multi_if.slave bus
);
   localparam int CH_W   = $clog2(NUM_CH);
   localparam int PROD_W = LOG2_MAX_DIST + SINE_WIDTH;

   logic [PHASE_WIDTH-1:0] phase_q [NUM_CH];
   logic [PHASE_WIDTH-1:0] step_q  [NUM_CH];
   logic [WIDTH-1:0]       amp_q   [NUM_CH];
   am_mode_e               mode_q  [NUM_CH];

   logic [CH_W-1:0]        issue_ch_q;
   logic [CH_W-1:0]        issue_ch_d;
   logic [PHASE_WIDTH-1:0] issue_phase;
   am_mode_e               issue_mode;
   logic [WIDTH-1:0]       issue_amp;

   logic                   s1_valid_q;
   logic [CH_W-1:0]        s1_ch_q;
   am_mode_e               s1_mode_q;
   logic [WIDTH-1:0]       s1_amp_q;
   logic [SINE_WIDTH-1:0]  lut_sine;

   logic [PROD_W-1:0]      prod_d;
   logic                   sat_d;
   logic                   s2_valid_q;
   logic [CH_W-1:0]        s2_ch_q;
   am_mode_e               s2_mode_q;
   logic                   s2_sat_q;
   logic [PROD_W-1:0]      s2_prod_q;
   logic [SINE_WIDTH-1:0]  s2_sine_q;

   logic [SINE_WIDTH-1:0]  sample_d;
   logic                   out_valid_q;
   logic [CH_W-1:0]        out_ch_q;
   logic [SINE_WIDTH-1:0]  out_sample_q;

   // Issue stage: snapshot the selected channel's state for the pipeline.
   always_comb begin
      issue_ch_d  = issue_ch_q + CH_W'(1);
      issue_phase = phase_q[issue_ch_q];
      issue_mode  = mode_q[issue_ch_q];
      issue_amp   = amp_q[issue_ch_q];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         issue_ch_q <= '0;
      end else if (enable) begin
         issue_ch_q <= issue_ch_d;
      end
   end

   // Config writes ignore enable; a phase clear is ordered after the
   // increment so it wins when it targets the channel being issued.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            phase_q[i] <= '0;
            step_q[i]  <= '0;
            amp_q[i]   <= '0;
            mode_q[i]  <= MUTE_MODE;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (enable && (issue_ch_q == CH_W'(i))) begin
               phase_q[i] <= phase_q[i] + step_q[i];
            end
            if (bus.cfg_we && (bus.cfg_ch == CH_W'(i))) begin
               step_q[i] <= bus.cfg_step;
               amp_q[i]  <= bus.cfg_amp;
               mode_q[i] <= am_mode_e'(bus.cfg_mode);
               if (bus.cfg_phase_clr) begin
                  phase_q[i] <= '0;
               end
            end
         end
      end
   end

   sine_LUT #(
      .PHASE_INTEGER_WIDTH (PHASE_INTEGER_WIDTH),
      .SINE_WIDTH          (SINE_WIDTH)
   ) u_sine_lut (
      .clk    (clk),
      .enable (enable),
      .phase  (issue_phase[PHASE_WIDTH-1 -: PHASE_INTEGER_WIDTH]),
      .sine   (lut_sine)
   );

   // Stage 1 runs alongside the ROM read register.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s1_ch_q    <= '0;
         s1_mode_q  <= MUTE_MODE;
         s1_amp_q   <= '0;
      end else if (enable) begin
         s1_valid_q <= 1'b1;
         s1_ch_q    <= issue_ch_q;
         s1_mode_q  <= issue_mode;
         s1_amp_q   <= issue_amp;
      end
   end

   always_comb begin
      prod_d = PROD_W'(s1_amp_q[LOG2_MAX_DIST-1:0]) * PROD_W'(lut_sine);
      sat_d  = |s1_amp_q[WIDTH-1:LOG2_MAX_DIST];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s2_valid_q <= 1'b0;
         s2_ch_q    <= '0;
         s2_mode_q  <= MUTE_MODE;
         s2_sat_q   <= 1'b0;
         s2_prod_q  <= '0;
         s2_sine_q  <= '0;
      end else if (enable) begin
         s2_valid_q <= s1_valid_q;
         s2_ch_q    <= s1_ch_q;
         s2_mode_q  <= s1_mode_q;
         s2_sat_q   <= sat_d;
         s2_prod_q  <= prod_d;
         s2_sine_q  <= lut_sine;
      end
   end

   // The product's top SINE_WIDTH bits are (amp * sine) >> LOG2_MAX_DIST.
   always_comb begin
      sample_d = '0;
      case (s2_mode_q)
         AM_MODE: sample_d = s2_sat_q ? s2_sine_q : s2_prod_q[PROD_W-1 -: SINE_WIDTH];
         CW_MODE: sample_d = s2_sine_q;
         default: sample_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q  <= 1'b0;
         out_ch_q     <= '0;
         out_sample_q <= '0;
      end else begin
         out_valid_q <= enable && s2_valid_q;
         if (enable && s2_valid_q) begin
            out_ch_q     <= s2_ch_q;
            out_sample_q <= sample_d;
         end
      end
   end

   assign bus.out_valid  = out_valid_q;
   assign bus.out_ch     = out_ch_q;
   assign bus.out_sample = out_sample_q;

endmodule

// File: tb/tb_am_mod_multi.sv
// Randomized bench for am_mod_multi against a channel-level behavioural model
// that computes each sample from real-valued sine and expected output timing.
module tb_am_mod_multi;
   import am_pkg::*;

   localparam int  NCH  = 4;
   localparam int  W    = 13;
   localparam int  SW   = 7;
   localparam int  PW   = 32;
   localparam int  PIW  = 12;
   localparam int  L2   = 11;
   localparam int  CHW  = $clog2(NCH);
   localparam real M_PI = 3.14159265358979323846;

   logic clk = 1'b0;
   logic reset;
   logic enable;

   always #5 clk = ~clk;

   am_mod_multi_if #(.NUM_CH(NCH), .WIDTH(W), .SINE_WIDTH(SW), .PHASE_WIDTH(PW)) bus ();

   am_mod_multi #(
      .NUM_CH              (NCH),
      .WIDTH               (W),
      .SINE_WIDTH          (SW),
      .PHASE_WIDTH         (PW),
      .PHASE_INTEGER_WIDTH (PIW),
      .LOG2_MAX_DIST       (L2)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .bus    (bus)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      int ch;
      int sample;
      int due;
   } exp_t;

   logic [PW-1:0] m_phase [NCH];
   logic [PW-1:0] m_step  [NCH];
   int            m_amp   [NCH];
   int            m_mode  [NCH];
   int            m_cnt    = 0;
   int            en_edges = 0;
   int            last_ch  = 0;
   int            last_smp = 0;
   exp_t          pend[$];

   function automatic int ref_sine(input logic [PW-1:0] ph);
      int  a;
      real th;
      a  = int'(ph >> (PW - PIW));
      th = 2.0 * M_PI * real'(a) / real'(2 ** PIW);
      return (2 ** (SW - 1)) + $rtoi($floor(real'(2 ** (SW - 1) - 1) * $sin(th) + 0.5));
   endfunction

   function automatic int ref_out(input int mode, input int amp, input int s);
      if (mode >= 2) return 0;
      if (mode == 1) return s;
      if (amp >= 2 ** L2) return s;
      return (amp * s) / (2 ** L2);
   endfunction

   initial begin
      forever begin
         bit   exp_v;
         int   ch;
         int   c;
         exp_t e;
         @(posedge clk);
         exp_v = 1'b0;
         if (reset) begin
            for (int i = 0; i < NCH; i++) begin
               m_phase[i] = '0;
               m_step[i]  = '0;
               m_amp[i]   = 0;
               m_mode[i]  = 2;
            end
            m_cnt    = 0;
            last_ch  = 0;
            last_smp = 0;
            pend.delete();
         end else begin
            if (enable) begin
               ch       = m_cnt;
               e.ch     = ch;
               e.sample = ref_out(m_mode[ch], m_amp[ch], ref_sine(m_phase[ch]));
               e.due    = en_edges + 2;
               pend.push_back(e);
               m_phase[ch] = m_phase[ch] + m_step[ch];
               m_cnt       = (m_cnt + 1) % NCH;
            end
            if (bus.cfg_we) begin
               c         = int'(bus.cfg_ch);
               m_step[c] = bus.cfg_step;
               m_amp[c]  = int'(bus.cfg_amp);
               m_mode[c] = int'(bus.cfg_mode);
               if (bus.cfg_phase_clr) m_phase[c] = '0;
            end
            if (enable) begin
               while (pend.size() > 0 && pend[0].due < en_edges) void'(pend.pop_front());
               if (pend.size() > 0 && pend[0].due == en_edges) begin
                  exp_v    = 1'b1;
                  last_ch  = pend[0].ch;
                  last_smp = pend[0].sample;
                  void'(pend.pop_front());
               end
               en_edges++;
            end
         end
         #1;
         check_eq("out_valid", 64'(bus.out_valid), 64'(exp_v));
         check_eq("out_ch", 64'(bus.out_ch), 64'(last_ch));
         check_eq("out_sample", 64'(bus.out_sample), 64'(last_smp));
         if (exp_v)
            $display("t=%0t sample ch=%0d value=%0d", $time, bus.out_ch, bus.out_sample);
      end
   end

   // ---------------- stimulus ----------------
   task automatic cfg(input int ch, input logic [PW-1:0] step, input int amp, input int mode, input bit clr);
      bus.cfg_we        = 1'b1;
      bus.cfg_ch        = CHW'(ch);
      bus.cfg_step      = step;
      bus.cfg_amp       = W'(amp);
      bus.cfg_mode      = 2'(mode);
      bus.cfg_phase_clr = clr;
      @(negedge clk);
      bus.cfg_we        = 1'b0;
      bus.cfg_phase_clr = 1'b0;
   endtask

   task automatic align_ch0();
      for (int k = 0; k < NCH && m_cnt != 0; k++) @(negedge clk);
   endtask

   task automatic random_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         enable            = ($urandom_range(0, 9) != 0);
         bus.cfg_we        = ($urandom_range(0, 4) == 0);
         bus.cfg_ch        = CHW'($urandom_range(0, NCH - 1));
         bus.cfg_step      = $urandom;
         bus.cfg_mode      = 2'($urandom_range(0, 3));
         bus.cfg_phase_clr = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 4))
            0:       bus.cfg_amp = W'(0);
            1:       bus.cfg_amp = W'(1024);
            2:       bus.cfg_amp = W'(2048);
            3:       bus.cfg_amp = W'(4095);
            default: bus.cfg_amp = W'($urandom_range(0, 2 ** W - 1));
         endcase
         @(negedge clk);
      end
      bus.cfg_we        = 1'b0;
      bus.cfg_phase_clr = 1'b0;
      enable            = 1'b1;
   endtask

   initial begin
      reset             = 1'b1;
      enable            = 1'b0;
      bus.cfg_we        = 1'b0;
      bus.cfg_ch        = '0;
      bus.cfg_step      = '0;
      bus.cfg_amp       = '0;
      bus.cfg_mode      = 2'd0;
      bus.cfg_phase_clr = 1'b0;
      repeat (3) @(negedge clk);

      // all channels muted after reset
      reset  = 1'b0;
      enable = 1'b1;
      repeat (14) @(negedge clk);

      // ch1 CW tone, ch2 AM at several amplitudes
      cfg(1, FREQ_STEP_500K, 0, 1, 1'b1);
      cfg(2, 32'h0123_4567, 1024, 0, 1'b0);
      repeat (16) @(negedge clk);
      cfg(2, 32'h0123_4567, 2048, 0, 1'b0);
      repeat (8) @(negedge clk);
      cfg(2, 32'h0123_4567, 4095, 0, 1'b0);
      repeat (8) @(negedge clk);
      cfg(2, 32'h0123_4567, 0, 0, 1'b0);
      repeat (8) @(negedge clk);

      // step change on ch0 in the very cycle ch0 is issued
      cfg(0, 32'h0400_0000, 0, 1, 1'b1);
      repeat (10) @(negedge clk);
      align_ch0();
      cfg(0, 32'h1100_0000, 0, 1, 1'b0);
      repeat (12) @(negedge clk);

      // 5-cycle enable gap mid-stream
      enable = 1'b0;
      repeat (5) @(negedge clk);
      enable = 1'b1;
      repeat (10) @(negedge clk);

      random_cycles(300);

      // reset with samples in flight, colliding with a config write
      repeat (6) @(negedge clk);
      reset             = 1'b1;
      bus.cfg_we        = 1'b1;
      bus.cfg_ch        = CHW'(0);
      bus.cfg_mode      = 2'd1;
      bus.cfg_phase_clr = 1'b1;
      @(negedge clk);
      reset             = 1'b0;
      bus.cfg_we        = 1'b0;
      bus.cfg_phase_clr = 1'b0;
      repeat (12) @(negedge clk);

      random_cycles(200);
      repeat (6) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/am_mod_multi.md
AM_MOD_MULTI -- requirements
Module: am_mod_multi

Interface
REQ-001 Parameter NUM_CH, default 4: number of time-multiplexed AM channels (power of 2, at least 2).
REQ-002 Parameter WIDTH, default 13: amplitude (distance) bit width.
REQ-003 Parameter SINE_WIDTH, default 7: unsigned sine sample width.
REQ-004 Parameter PHASE_WIDTH, default 32: phase accumulator width; PHASE_INTEGER_WIDTH, default 12: LUT address bits, taken from the phase MSBs.
REQ-005 Parameter LOG2_MAX_DIST, default 11: amplitude full-scale exponent, MAX_DIST = 2**LOG2_MAX_DIST.
REQ-006 clk  input  1  sole clock; all logic on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 enable  input  1  pipeline advance; low freezes every register except the config write.
REQ-009 cfg_we  input  1  config write strobe for channel cfg_ch.
REQ-010 cfg_ch  input  $clog2(NUM_CH)  config target channel.
REQ-011 cfg_step  input  PHASE_WIDTH  per-channel frequency step.
REQ-012 cfg_amp  input  WIDTH  per-channel amplitude.
REQ-013 cfg_mode  input  2  per-channel mode: 0 AM, 1 CW, 2 MUTE, 3 MUTE.
REQ-014 cfg_phase_clr  input  1  with cfg_we, zero the target channel phase.
REQ-015 out_valid  output  1  out_sample/out_ch valid this cycle.
REQ-016 out_ch  output  $clog2(NUM_CH)  channel of out_sample.
REQ-017 out_sample  output  SINE_WIDTH  modulated sample.

Function
REQ-018 Issue counter: one channel issued per enable cycle, round-robin 0..NUM_CH-1, then wrapping to 0.
REQ-019 Issue stage: present phase[ch] to the LUT; phase[ch] <= phase[ch] + step[ch], modulo 2**PHASE_WIDTH.
REQ-020 Pipeline: issue, then LUT (1-cycle latency), then multiply, then output register; out_valid is asserted 3 enabled cycles after issue.
REQ-021 Each pipeline stage carries its channel index and a snapshot of mode/amp taken at issue.
REQ-022 AM mode: amp < MAX_DIST gives out = (amp*sine) >> LOG2_MAX_DIST, truncated to SINE_WIDTH; amp >= MAX_DIST gives out = sine (saturate).
REQ-023 CW mode: out = sine; MUTE mode: out = 0, with the phase still advancing.
REQ-024 Multiply result width: LOG2_MAX_DIST+SINE_WIDTH bits; no overflow is possible below MAX_DIST.
REQ-025 enable low: stages hold; out_valid = 0; outputs keep their last sample/channel values.
REQ-026 Config write always takes effect at the clock edge, regardless of enable.
REQ-027 Config write to the channel being issued in the same cycle: the issue uses the old step/amp/mode; new values apply from the next issue of that channel.
REQ-028 cfg_phase_clr on the channel being issued: the clear wins; phase = 0, with no increment that cycle.
REQ-029 Samples already in flight are unaffected by later config writes.

Reset
REQ-030 reset: all phase, step, amp registers = 0; modes = MUTE; issue counter = 0.
REQ-031 reset: pipeline valid bits = 0; out_valid = 0; out_ch = 0; out_sample = 0.
REQ-032 reset mid-operation flushes in-flight samples; first out_valid comes 3 enabled cycles after reset deasserts, with out_ch = 0.
REQ-033 reset has priority over cfg_we and enable in the same cycle.

Structure
REQ-034 Package am_pkg holds the mode enum (AM_MODE, CW_MODE, MUTE_MODE) and default constants (FREQ_STEP_500K = 32'h028F5C29).
REQ-035 A single shared sine_LUT instance (clk, enable, phase, sine) is used; there are no per-channel LUTs.
REQ-036 Per-channel registers are arrays indexed by channel; one multiplier is shared by all channels.

Verification
REQ-037 Reset, then enable high with no config -> out_valid rises on the 3rd cycle, out_ch sequence is 0,1,2,3,0..., and all samples are 0 (MUTE).
REQ-038 ch1: CW, step 32'h028F5C29, phase_clr -> ch1 sample stream matches the sine_LUT model at phase n*step, with other channels at 0.
REQ-039 ch2: AM, amp 1024 -> out = floor(sine*1024/2048); amp 2048 and 4095 -> out = sine; amp 0 -> out = 0.
REQ-040 Write to ch0 in the same cycle ch0 is issued (step changed) -> that issue uses the old phase/step, and the new step is applied on the next ch0 issue.
REQ-041 Toggle enable low for 5 cycles mid-stream -> no out_valid during the gap, and the sequence resumes with no lost or duplicated channel.
REQ-042 Assert reset with 3 samples in flight -> out_valid = 0 next cycle, registers at reset values, and the channel order restarts at 0.
